operand_forward: RTL and testbench

RF-stage operand bypass and RAW scoreboard for the dual-issue SPU pipeline. Consumes the forwarding tables published by the even and odd pipes (stages 1–6 staging registers plus the stage-7 writeback value). Selects the youngest in-flight copy of each source operand, or falls back to the register-file read. Tracks issued-but-not-yet-forwardable destinations in a countdown scoreboard and stalls issue on a true RAW hazard or scoreboard full.

---
 rtl/operand_forward_if.sv | 44 ++++
 rtl/operand_forward.sv | 162 ++++++++++++++++
 tb/tb_operand_forward.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_forward_if.sv
`default_nettype none
// ============================================================================
// Module   : operand_forward_if
// Brief    : Issue, forwarding-table and resolved-operand bundle of the RF stage
// Revision : 1.0 - initial release
// ============================================================================
interface operand_forward_if;
  logic               issue_valid_e, issue_valid_o;
  logic [6:0]         rt_addr_e, rt_addr_o;
  logic               reg_write_e, reg_write_o;
  logic [2:0]         lat_e, lat_o;
  logic [6:0]         ra_addr_e, rb_addr_e, rc_addr_e, ra_addr_o, rb_addr_o;
  logic [127:0]       ra_rf_e, rb_rf_e, rc_rf_e, ra_rf_o, rb_rf_o;
  logic [6:0][127:0]  fw_e, fw_o;
  logic [6:0][6:0]    fw_addr_e, fw_addr_o;
  logic [6:0]         fw_write_e, fw_write_o;
  logic [127:0]       rt_wb_e, rt_wb_o;
  logic [6:0]         rt_addr_wb_e, rt_addr_wb_o;
  logic               reg_write_wb_e, reg_write_wb_o;
  logic               stall;
  logic               valid_e_q, valid_o_q;
  logic [127:0]       ra_e_q, rb_e_q, rc_e_q, ra_o_q, rb_o_q;

  modport master (
    output issue_valid_e, issue_valid_o, rt_addr_e, rt_addr_o, reg_write_e,
           reg_write_o, lat_e, lat_o, ra_addr_e, rb_addr_e, rc_addr_e,
           ra_addr_o, rb_addr_o, ra_rf_e, rb_rf_e, rc_rf_e, ra_rf_o, rb_rf_o,
           fw_e, fw_o, fw_addr_e, fw_addr_o, fw_write_e, fw_write_o,
           rt_wb_e, rt_wb_o, rt_addr_wb_e, rt_addr_wb_o, reg_write_wb_e,
           reg_write_wb_o,
    input  stall, valid_e_q, valid_o_q, ra_e_q, rb_e_q, rc_e_q, ra_o_q, rb_o_q
  );

  modport slave (
    input  issue_valid_e, issue_valid_o, rt_addr_e, rt_addr_o, reg_write_e,
           reg_write_o, lat_e, lat_o, ra_addr_e, rb_addr_e, rc_addr_e,
           ra_addr_o, rb_addr_o, ra_rf_e, rb_rf_e, rc_rf_e, ra_rf_o, rb_rf_o,
           fw_e, fw_o, fw_addr_e, fw_addr_o, fw_write_e, fw_write_o,
           rt_wb_e, rt_wb_o, rt_addr_wb_e, rt_addr_wb_o, reg_write_wb_e,
           reg_write_wb_o,
    output stall, valid_e_q, valid_o_q, ra_e_q, rb_e_q, rc_e_q, ra_o_q, rb_o_q
  );
endinterface
`default_nettype wire

// File: rtl/operand_forward.sv
`default_nettype none
// ============================================================================
// Module   : operand_forward
// Brief    : RF-stage operand bypass plus countdown RAW scoreboard for the
//            dual-issue pipe. Option: OPFWD_STALL_COUNT_EN adds stall_count.
// Revision : 1.0 - initial release
// ============================================================================
module operand_forward #(
  parameter int SB_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  operand_forward_if.slave bus
`ifdef OPFWD_STALL_COUNT_EN
  ,
  output logic [31:0]      stall_count
`endif
);
  localparam int IDX_W = $clog2(SB_DEPTH);

  logic [SB_DEPTH-1:0]      r_sb_valid;
  logic [SB_DEPTH-1:0][6:0] r_sb_addr;
  logic [SB_DEPTH-1:0][2:0] r_sb_cnt;
  logic                     r_valid_e, r_valid_o;
  logic [4:0][127:0]        r_opnd;

  logic [4:0][6:0]          w_src_addr;
  logic [4:0][127:0]        w_src_rf;
  logic [4:0][127:0]        w_src_res;
  logic [4:0]               w_src_live;
  logic                     w_hazard, w_full, w_stall;
  logic                     w_need_e, w_need_o, w_alloc_e, w_alloc_o;
  logic                     w_found_a, w_found_b;
  logic [IDX_W-1:0]         w_slot_a, w_slot_b, w_slot_e, w_slot_o;
  int                       w_free_count;

  // Operand order: ra_e, rb_e, rc_e, ra_o, rb_o
  assign w_src_addr = {bus.rb_addr_o, bus.ra_addr_o, bus.rc_addr_e, bus.rb_addr_e, bus.ra_addr_e};
  assign w_src_rf   = {bus.rb_rf_o, bus.ra_rf_o, bus.rc_rf_e, bus.rb_rf_e, bus.ra_rf_e};
  assign w_src_live = {bus.issue_valid_o, bus.issue_valid_o, bus.issue_valid_e,
                       bus.issue_valid_e, bus.issue_valid_e};

  function automatic logic [2:0] f_init_cnt(input logic [2:0] lat);
    return (lat < 3'd2) ? 3'd1 : lat - 3'd1;
  endfunction

  // Oldest candidates are applied first so younger matches overwrite them.
  always_comb begin
    w_src_res = w_src_rf;
    for (int k = 0; k < 5; k++) begin
      if (bus.reg_write_wb_e && bus.rt_addr_wb_e == w_src_addr[k]) w_src_res[k] = bus.rt_wb_e;
      if (bus.reg_write_wb_o && bus.rt_addr_wb_o == w_src_addr[k]) w_src_res[k] = bus.rt_wb_o;
      for (int s = 6; s >= 1; s--) begin
        if (bus.fw_write_e[s] && bus.fw_addr_e[s] == w_src_addr[k]) w_src_res[k] = bus.fw_e[s];
        if (bus.fw_write_o[s] && bus.fw_addr_o[s] == w_src_addr[k]) w_src_res[k] = bus.fw_o[s];
      end
    end
  end

  always_comb begin
    w_hazard = 1'b0;
    for (int k = 0; k < 5; k++)
      for (int j = 0; j < SB_DEPTH; j++)
        if (w_src_live[k] && r_sb_valid[j] && r_sb_cnt[j] != 3'd0 &&
            r_sb_addr[j] == w_src_addr[k])
          w_hazard = 1'b1;
  end

  always_comb begin
    w_free_count = 0;
    w_found_a    = 1'b0;
    w_found_b    = 1'b0;
    w_slot_a     = '0;
    w_slot_b     = '0;
    for (int j = 0; j < SB_DEPTH; j++) begin
      if (!r_sb_valid[j]) begin
        w_free_count = w_free_count + 1;
        if (!w_found_a) begin
          w_found_a = 1'b1;
          w_slot_a  = IDX_W'(j);
        end else if (!w_found_b) begin
          w_found_b = 1'b1;
          w_slot_b  = IDX_W'(j);
        end
      end
    end
  end

  assign w_need_e  = bus.issue_valid_e & bus.reg_write_e;
  assign w_need_o  = bus.issue_valid_o & bus.reg_write_o;
  assign w_full    = w_free_count < (int'(w_need_e) + int'(w_need_o));
  assign w_stall   = (bus.issue_valid_e | bus.issue_valid_o) & (w_hazard | w_full);
  assign w_alloc_e = w_need_e & ~w_stall;
  assign w_alloc_o = w_need_o & ~w_stall;
  assign w_slot_e  = w_slot_a;
  assign w_slot_o  = w_need_e ? w_slot_b : w_slot_a;

  // Allocation only targets free slots, so it never collides with a countdown.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sb_valid <= '0;
      r_sb_addr  <= '0;
      r_sb_cnt   <= '0;
    end else begin
      for (int j = 0; j < SB_DEPTH; j++) begin
        if (r_sb_valid[j]) begin
          r_sb_cnt[j] <= r_sb_cnt[j] - 3'd1;
          if (r_sb_cnt[j] <= 3'd1) r_sb_valid[j] <= 1'b0;
        end
      end
      if (w_alloc_e) begin
        r_sb_valid[w_slot_e] <= 1'b1;
        r_sb_addr[w_slot_e]  <= bus.rt_addr_e;
        r_sb_cnt[w_slot_e]   <= f_init_cnt(bus.lat_e);
      end
      if (w_alloc_o) begin
        r_sb_valid[w_slot_o] <= 1'b1;
        r_sb_addr[w_slot_o]  <= bus.rt_addr_o;
        r_sb_cnt[w_slot_o]   <= f_init_cnt(bus.lat_o);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid_e <= 1'b0;
      r_valid_o <= 1'b0;
      r_opnd    <= '0;
    end else if (w_stall) begin
      r_valid_e <= 1'b0;
      r_valid_o <= 1'b0;
    end else begin
      r_valid_e <= bus.issue_valid_e;
      r_valid_o <= bus.issue_valid_o;
      r_opnd    <= w_src_res;
    end
  end

`ifdef OPFWD_STALL_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      stall_count <= '0;
    else if (w_stall && stall_count != 32'hFFFF_FFFF)
      stall_count <= stall_count + 32'd1;
  end
`endif

  // Stage 0 of each forwarding table carries nothing resolvable.
  logic w_unused_fw0;
  assign w_unused_fw0 = ^{bus.fw_e[0], bus.fw_o[0], bus.fw_addr_e[0], bus.fw_addr_o[0],
                          bus.fw_write_e[0], bus.fw_write_o[0]};

  assign bus.stall     = w_stall;
  assign bus.valid_e_q = r_valid_e;
  assign bus.valid_o_q = r_valid_o;
  assign bus.ra_e_q    = r_opnd[0];
  assign bus.rb_e_q    = r_opnd[1];
  assign bus.rc_e_q    = r_opnd[2];
  assign bus.ra_o_q    = r_opnd[3];
  assign bus.rb_o_q    = r_opnd[4];
endmodule
`default_nettype wire

// File: tb/tb_operand_forward.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_forward
// Brief    : Directed plus random bench for operand_forward against a
//            producer-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_operand_forward;
  localparam int SB_DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  operand_forward_if ifc ();

`ifdef OPFWD_STALL_COUNT_EN
  logic [31:0] stall_count;
  logic [31:0] m_stall_count = '0;
`endif

  operand_forward #(.SB_DEPTH(SB_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
`ifdef OPFWD_STALL_COUNT_EN
    ,
    .stall_count (stall_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: every accepted writer is remembered with the cycle in
  // which its value first appears on the forwarding chain.
  int           m_addr[$];
  int           m_ready[$];
  logic         m_valid_e = 1'b0;
  logic         m_valid_o = 1'b0;
  logic [127:0] m_opnd[5] = '{default: '0};

  function automatic logic [127:0] r128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [127:0] m_resolve(input logic [6:0] a, input logic [127:0] rf);
    for (int s = 1; s <= 6; s++) begin
      if (ifc.fw_write_o[s] && ifc.fw_addr_o[s] == a) return ifc.fw_o[s];
      if (ifc.fw_write_e[s] && ifc.fw_addr_e[s] == a) return ifc.fw_e[s];
    end
    if (ifc.reg_write_wb_o && ifc.rt_addr_wb_o == a) return ifc.rt_wb_o;
    if (ifc.reg_write_wb_e && ifc.rt_addr_wb_e == a) return ifc.rt_wb_e;
    return rf;
  endfunction

  function automatic bit m_pending(input logic [6:0] a);
    foreach (m_addr[i]) if (m_addr[i] == int'(a)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int lat_of(input logic [2:0] l);
    return (l < 3'd2) ? 2 : int'(l);
  endfunction

  task automatic idle();
    ifc.issue_valid_e = 0; ifc.issue_valid_o = 0;
    ifc.reg_write_e = 0;   ifc.reg_write_o = 0;
    ifc.rt_addr_e = 0;     ifc.rt_addr_o = 0;
    ifc.lat_e = 0;         ifc.lat_o = 0;
    ifc.ra_addr_e = 0; ifc.rb_addr_e = 0; ifc.rc_addr_e = 0;
    ifc.ra_addr_o = 0; ifc.rb_addr_o = 0;
    ifc.ra_rf_e = r128(); ifc.rb_rf_e = r128(); ifc.rc_rf_e = r128();
    ifc.ra_rf_o = r128(); ifc.rb_rf_o = r128();
    ifc.fw_e = '0; ifc.fw_o = '0; ifc.fw_addr_e = '0; ifc.fw_addr_o = '0;
    ifc.fw_write_e = '0; ifc.fw_write_o = '0;
    ifc.rt_wb_e = r128(); ifc.rt_wb_o = r128();
    ifc.rt_addr_wb_e = 0; ifc.rt_addr_wb_o = 0;
    ifc.reg_write_wb_e = 0; ifc.reg_write_wb_o = 0;
  endtask

  task automatic rnd_inputs();
    idle();
    ifc.issue_valid_e = 1'($urandom_range(0, 1));
    ifc.issue_valid_o = 1'($urandom_range(0, 1));
    ifc.reg_write_e = 1'($urandom_range(0, 1));
    ifc.reg_write_o = 1'($urandom_range(0, 1));
    ifc.rt_addr_e = 7'($urandom_range(0, 31)); ifc.rt_addr_o = 7'($urandom_range(0, 31));
    ifc.lat_e = 3'($urandom); ifc.lat_o = 3'($urandom);
    ifc.ra_addr_e = 7'($urandom_range(0, 31)); ifc.rb_addr_e = 7'($urandom_range(0, 31));
    ifc.rc_addr_e = 7'($urandom_range(0, 31)); ifc.ra_addr_o = 7'($urandom_range(0, 31));
    ifc.rb_addr_o = 7'($urandom_range(0, 31));
    for (int s = 0; s < 7; s++) begin
      ifc.fw_e[s] = r128(); ifc.fw_o[s] = r128();
      ifc.fw_addr_e[s] = 7'($urandom_range(0, 31)); ifc.fw_addr_o[s] = 7'($urandom_range(0, 31));
    end
    ifc.fw_write_e = 7'($urandom); ifc.fw_write_o = 7'($urandom);
    ifc.rt_addr_wb_e = 7'($urandom_range(0, 31)); ifc.rt_addr_wb_o = 7'($urandom_range(0, 31));
    ifc.reg_write_wb_e = 1'($urandom_range(0, 1)); ifc.reg_write_wb_o = 1'($urandom_range(0, 1));
  endtask

  // One clock: check stall mid-cycle, advance the model at the edge, check outputs.
  task automatic do_cycle(output logic obs_stall);
    logic         exp_stall, haz;
    int           need;
    logic [6:0]   srcs[5];
    logic [127:0] rfs[5];
    logic [127:0] res[5];
    @(negedge clk);
    for (int i = m_addr.size() - 1; i >= 0; i--)
      if (m_ready[i] <= cyc) begin m_addr.delete(i); m_ready.delete(i); end
    srcs = '{ifc.ra_addr_e, ifc.rb_addr_e, ifc.rc_addr_e, ifc.ra_addr_o, ifc.rb_addr_o};
    rfs  = '{ifc.ra_rf_e, ifc.rb_rf_e, ifc.rc_rf_e, ifc.ra_rf_o, ifc.rb_rf_o};
    haz = 1'b0;
    for (int k = 0; k < 5; k++)
      if ((k < 3 ? ifc.issue_valid_e : ifc.issue_valid_o) && m_pending(srcs[k])) haz = 1'b1;
    need = int'(ifc.issue_valid_e && ifc.reg_write_e) + int'(ifc.issue_valid_o && ifc.reg_write_o);
    exp_stall = (ifc.issue_valid_e || ifc.issue_valid_o) &&
                (haz || (SB_DEPTH - m_addr.size()) < need);
    obs_stall = ifc.stall;
    chk("stall", ifc.stall, exp_stall);
    for (int k = 0; k < 5; k++) res[k] = m_resolve(srcs[k], rfs[k]);
    @(posedge clk);
    #1;
    if (reset) begin
      m_addr.delete(); m_ready.delete();
      m_valid_e = 0; m_valid_o = 0; m_opnd = '{default: '0};
    end else if (exp_stall) begin
      m_valid_e = 0; m_valid_o = 0;
    end else begin
      if (ifc.issue_valid_e && ifc.reg_write_e) begin
        m_addr.push_back(int'(ifc.rt_addr_e)); m_ready.push_back(cyc + lat_of(ifc.lat_e));
      end
      if (ifc.issue_valid_o && ifc.reg_write_o) begin
        m_addr.push_back(int'(ifc.rt_addr_o)); m_ready.push_back(cyc + lat_of(ifc.lat_o));
      end
      m_valid_e = ifc.issue_valid_e; m_valid_o = ifc.issue_valid_o;
      m_opnd = res;
    end
    cyc++;
    chk("valid_e_q", ifc.valid_e_q, m_valid_e);
    chk("valid_o_q", ifc.valid_o_q, m_valid_o);
    chk("ra_e_q", ifc.ra_e_q, m_opnd[0]);
    chk("rb_e_q", ifc.rb_e_q, m_opnd[1]);
    chk("rc_e_q", ifc.rc_e_q, m_opnd[2]);
    chk("ra_o_q", ifc.ra_o_q, m_opnd[3]);
    chk("rb_o_q", ifc.rb_o_q, m_opnd[4]);
`ifdef OPFWD_STALL_COUNT_EN
    if (reset) m_stall_count = '0;
    else if (exp_stall && m_stall_count != 32'hFFFF_FFFF) m_stall_count++;
    chk("stall_count", stall_count, m_stall_count);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cyc=%0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic         st;
    int           n;
    logic [127:0] x, y, w;

    idle();
    reset = 1'b1;
    do_cycle(st);
    do_cycle(st);
    reset = 1'b0;
    chk("reset_ra_e_q", ifc.ra_e_q, '0);
    chk("reset_valid_e_q", ifc.valid_e_q, 1'b0);

    // Producer rt=5 lat=4 followed by an odd consumer of r5
    idle();
    ifc.issue_valid_e = 1; ifc.reg_write_e = 1; ifc.rt_addr_e = 5; ifc.lat_e = 4;
    do_cycle(st);
    chk("producer_accept", st, 1'b0);
    idle();
    ifc.issue_valid_o = 1; ifc.ra_addr_o = 5;
    repeat (3) begin
      do_cycle(st);
      chk("raw_stall", st, 1'b1);
    end
    ifc.fw_e[4] = {16{8'hAA}}; ifc.fw_addr_e[4] = 5; ifc.fw_write_e[4] = 1;
    do_cycle(st);
    chk("raw_release", st, 1'b0);
    chk("raw_fwd_ra_o", ifc.ra_o_q, {16{8'hAA}});
    chk("raw_fwd_valid_o", ifc.valid_o_q, 1'b1);

    // Younger stage beats older; odd beats even at the same stage
    idle();
    x = r128(); y = r128();
    ifc.issue_valid_e = 1; ifc.rb_addr_e = 9;
    ifc.fw_e[2] = x; ifc.fw_addr_e[2] = 9; ifc.fw_write_e[2] = 1;
    ifc.fw_o[5] = y; ifc.fw_addr_o[5] = 9; ifc.fw_write_o[5] = 1;
    do_cycle(st);
    chk("prio_younger_stage", ifc.rb_e_q, x);
    ifc.fw_write_e = '0; ifc.fw_write_o = '0;
    ifc.fw_e[3] = x; ifc.fw_addr_e[3] = 9; ifc.fw_write_e[3] = 1;
    ifc.fw_o[3] = y; ifc.fw_addr_o[3] = 9; ifc.fw_write_o[3] = 1;
    do_cycle(st);
    chk("prio_odd_same_stage", ifc.rb_e_q, y);

    // Writeback source versus register file
    idle();
    w = r128();
    ifc.issue_valid_e = 1; ifc.ra_addr_e = 12;
    ifc.rt_wb_e = w; ifc.rt_addr_wb_e = 12; ifc.reg_write_wb_e = 1;
    do_cycle(st);
    chk("wb_select", ifc.ra_e_q, w);
    ifc.reg_write_wb_e = 0;
    do_cycle(st);
    chk("rf_fallback", ifc.ra_e_q, ifc.ra_rf_e);

    // Fill all eight entries with lat=7 pairs, then a ninth writer
    idle();
    for (int p = 0; p < 4; p++) begin
      ifc.issue_valid_e = 1; ifc.reg_write_e = 1; ifc.rt_addr_e = 7'(20 + 2 * p); ifc.lat_e = 7;
      ifc.issue_valid_o = 1; ifc.reg_write_o = 1; ifc.rt_addr_o = 7'(21 + 2 * p); ifc.lat_o = 7;
      do_cycle(st);
      chk("fill_accept", st, 1'b0);
    end
    idle();
    ifc.issue_valid_e = 1; ifc.reg_write_e = 1; ifc.rt_addr_e = 30; ifc.lat_e = 7;
    n = 0;
    do begin
      do_cycle(st);
      if (st) n++;
    end while (st && n < 12);
    chk("full_stall_cycles", n, 3);
    idle();
    repeat (8) do_cycle(st);

    // Reset with pending writers leaves no stale hazard
    ifc.issue_valid_e = 1; ifc.reg_write_e = 1; ifc.rt_addr_e = 40; ifc.lat_e = 7;
    ifc.issue_valid_o = 1; ifc.reg_write_o = 1; ifc.rt_addr_o = 41; ifc.lat_o = 7;
    do_cycle(st);
    idle();
    ifc.issue_valid_e = 1; ifc.reg_write_e = 1; ifc.rt_addr_e = 42; ifc.lat_e = 7;
    do_cycle(st);
    idle();
    reset = 1'b1;
    do_cycle(st);
    reset = 1'b0;
    ifc.issue_valid_e = 1; ifc.ra_addr_e = 40; ifc.rb_addr_e = 41; ifc.rc_addr_e = 42;
    do_cycle(st);
    chk("post_reset_no_stall", st, 1'b0);
    chk("post_reset_rf_ra", ifc.ra_e_q, ifc.ra_rf_e);
    chk("post_reset_rf_rc", ifc.rc_e_q, ifc.rc_rf_e);

    // Five hazard cycles from a lat=6 producer
    idle();
    ifc.issue_valid_o = 1; ifc.reg_write_o = 1; ifc.rt_addr_o = 50; ifc.lat_o = 6;
    do_cycle(st);
    idle();
    ifc.issue_valid_e = 1; ifc.rb_addr_e = 50;
    n = 0;
    do begin
      do_cycle(st);
      if (st) n++;
    end while (st && n < 10);
    chk("hazard_cycles", n, 5);
`ifdef OPFWD_STALL_COUNT_EN
    chk("stall_count_five", stall_count, 32'd5);
`endif

    // Random traffic, occasional reset
    for (int c = 0; c < 400; c++) begin
      rnd_inputs();
      reset = ($urandom_range(0, 63) == 0);
      do_cycle(st);
    end
    reset = 1'b0;
    idle();
    repeat (8) do_cycle(st);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
